// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: turns pc into an imem word address and buffers one instruction for decode; drives the PC register's load/D inputs.
// Latency is 1 cycle plus memory wait states. The next fetch starts after decode accepts, and redirects squash the wrong-path fetch.
module instr_fetch_ctrl #(
    parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
    parameter int          AW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc,
    output logic [31:0]   pc_next,
    output logic          pc_load,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_target,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    output logic          instr_valid,
    input  logic          decode_ready,
    output logic          fetch_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] r_pend;
    logic        w_capture;
    logic        w_pend_wr;
    logic        w_go_fetch;
    logic [31:0] w_pc_inc;
    logic [31:0] w_off;
    logic [31:0] w_pc_after;
    logic [31:0] w_off_after;
    logic        w_after_bad;

    assign w_pc_inc  = pc + 32'd4;
    assign w_off     = pc - TEXT_BASE;
    assign imem_addr = AW'(w_off >> 2);

    assign imem_req    = (r_state == S_FETCH) || (r_state == S_FLUSH);
    assign instr_valid = (r_state == S_HOLD);
    assign fetch_err   = (r_state == S_ERR);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

    always_comb begin
        pc_load     = 1'b0;
        pc_next     = w_pc_inc;
        w_capture   = 1'b0;
        w_pend_wr   = 1'b0;
        w_go_fetch  = 1'b0;
        w_state_nxt = r_state;
        w_pc_after  = pc;
        w_off_after = 32'd0;
        w_after_bad = 1'b0;
        case (r_state)
            S_IDLE: w_go_fetch = 1'b1;
            S_FETCH: begin
                if (imem_ready) begin
                    pc_load = 1'b1;
                    if (redirect_valid) begin
                        pc_next    = redirect_target;
                        w_go_fetch = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_pend_wr   = 1'b1;
                    w_state_nxt = S_FLUSH;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_load    = 1'b1;
                    pc_next    = redirect_target;
                    w_go_fetch = 1'b1;
                end else if (decode_ready) begin
                    w_go_fetch = 1'b1;
                end
            end
            S_FLUSH: begin
                // A redirect landing on the response edge beats the pending target.
                if (imem_ready) begin
                    pc_load    = 1'b1;
                    pc_next    = redirect_valid ? redirect_target : r_pend;
                    w_go_fetch = 1'b1;
                end else if (redirect_valid) begin
                    w_pend_wr = 1'b1;
                end
            end
            S_ERR: begin
                if (redirect_valid) begin
                    pc_load    = 1'b1;
                    pc_next    = redirect_target;
                    w_go_fetch = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Validate the pc the next FETCH will see, so a bad address never raises imem_req.
        w_pc_after  = pc_load ? pc_next : pc;
        w_off_after = w_pc_after - TEXT_BASE;
        w_after_bad = (w_pc_after[1:0] != 2'b00) || (w_pc_after < TEXT_BASE) ||
                      ((w_off_after >> (AW + 2)) != 32'd0);
        if (w_go_fetch) begin
            w_state_nxt = w_after_bad ? S_ERR : S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
            r_pend     <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= pc;
            end
            if (w_pend_wr) begin
                r_pend <= redirect_target;
            end
        end
    end

endmodule
